// File: rtl/dm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_ctrl_pkg
// Description : Shared definitions for the data-memory access controller.
//               Provides the access-size encodings, the controller FSM state
//               type and the legality check applied to every request.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_ctrl_pkg;

    // Access size encodings as presented on size0/size1.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Returns 1 when a request may touch DM: legal size, naturally aligned,
    // and its containing word lies at or below last_word.
    function automatic logic access_ok(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] last_word);
        logic aligned;
        case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            SZ_WORD: aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned && ({addr[31:2], 2'b00} <= last_word);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_merge
// Description : Combinational byte-lane datapath for the DM access controller.
//               Load path: picks the addressed byte/half/word out of the DM
//               read word and zero-extends it to 32 bits.
//               Store path: builds the full word to write back, replacing the
//               addressed lane(s) of the merge buffer with store data.
// Ports       : size_i    - access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//               lane_i    - byte address bits [1:0]
//               rd_word_i - word read from DM (little-endian)
//               merge_i   - previously read word for read-modify-write
//               wdata_i   - right-aligned store data
//               load_o    - right-aligned, zero-extended load data
//               store_o   - full word to present on DM writeData
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_merge
    import dm_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] merge_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    // Bit offsets of the addressed byte lane and halfword lane pair.
    logic [4:0] byte_ofs;
    logic [4:0] half_ofs;

    assign byte_ofs = {lane_i, 3'b000};
    assign half_ofs = {lane_i[1], 4'b0000};

    always_comb begin
        load_o = '0;
        case (size_i)
            SZ_BYTE: load_o = {24'd0, rd_word_i[byte_ofs +: 8]};
            SZ_HALF: load_o = {16'd0, rd_word_i[half_ofs +: 16]};
            SZ_WORD: load_o = rd_word_i;
            default: load_o = '0;
        endcase
    end

    always_comb begin
        store_o = merge_i;
        case (size_i)
            SZ_BYTE: store_o[byte_ofs +: 8]  = wdata_i[7:0];
            SZ_HALF: store_o[half_ofs +: 16] = wdata_i[15:0];
            SZ_WORD: store_o = wdata_i;
            default: store_o = merge_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Arbitrates the single-port data memory between the CPU
//               load/store stage (port 0) and the DMA/debug loader (port 1).
//               Checks alignment/range, performs loads, word stores, and
//               byte/half stores via read-modify-write on a word-only DM.
// Ports       : clk, rst_n            - clock, async active-low reset
//               reqN/weN/sizeN/addrN/wdataN - requester N operands (held
//                                      until ackN)
//               rdataN/ackN/errN      - requester N response
//               busy                  - controller not idle
//               mem_addr/mem_wdata/mem_read/mem_write/mem_rdata - DM side
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter bit          RST_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_e      state_q, state_d;
    logic        prio_q,  prio_d;
    logic        port_q,  port_d;
    logic        we_q,    we_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q,   err_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        grant;
    logic [31:0] load_word;
    logic [31:0] store_word;

    dm_lane_merge u_lane_merge (
        .size_i    (size_q),
        .lane_i    (addr_q[1:0]),
        .rd_word_i (mem_rdata),
        .merge_i   (merge_q),
        .wdata_i   (wdata_q),
        .load_o    (load_word),
        .store_o   (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prio_q   <= RST_PRIO;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            port_q   <= port_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            merge_q  <= merge_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        port_d   = port_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        merge_d  = merge_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant    = prio_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Priority only rotates when both ports actually collide.
                    if (req0 && req1) begin
                        grant  = prio_q;
                        prio_d = ~prio_q;
                    end else begin
                        grant  = req1;
                    end
                    port_d  = grant;
                    we_d    = grant ? we1    : we0;
                    size_d  = grant ? size1  : size0;
                    addr_d  = grant ? addr1  : addr0;
                    wdata_d = grant ? wdata1 : wdata0;

                    if (!access_ok(size_d, addr_d, LAST_WORD)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d = 1'b0;
                        if (!we_d) begin
                            state_d = ST_RD;
                        end else if (size_d == SZ_WORD) begin
                            state_d = ST_WR;
                        end else begin
                            state_d = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                if (port_q) begin
                    rdata1_d = load_word;
                end else begin
                    rdata0_d = load_word;
                end
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                merge_d = mem_rdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All DM strobes decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign mem_read  = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    assign mem_write = (state_q == ST_WR);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_write ? store_word : 32'd0;

    assign busy   = (state_q != ST_IDLE);
    assign ack0   = (state_q == ST_RESP) && !port_q;
    assign ack1   = (state_q == ST_RESP) &&  port_q;
    assign err0   = ack0 && err_q;
    assign err1   = ack1 && err_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_ctrl
// Description : Self-checking bench for dm_access_ctrl. A word-wide DM model
//               serves the DUT; a byte-addressed reference memory predicts
//               load data, write words, errors, latency and grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    localparam int          MEM_BYTES = 1024;
    localparam bit          RST_PRIO  = 1'b0;
    localparam int          AW        = $clog2(MEM_BYTES);
    localparam int          NRAND     = 200;
    localparam int          BOUND     = 20;
    localparam logic [1:0]  T_BYTE    = 2'b00;
    localparam logic [1:0]  T_HALF    = 2'b01;
    localparam logic [1:0]  T_WORD    = 2'b10;
    localparam logic [1:0]  T_ILL     = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [1:0]  size0 = '0, size1 = '0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic        ack0, ack1, err0, err1, busy, mem_read, mem_write;

    always #5 clk = ~clk;

    dm_access_ctrl #(.MEM_BYTES(MEM_BYTES), .RST_PRIO(RST_PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .rdata0(rdata0), .rdata1(rdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Word-only DM: combinational read, commit on rising clk while mem_write.
    logic [31:0] dm [MEM_BYTES/4] = '{default: 32'd0};
    assign mem_rdata = (mem_addr < 32'(MEM_BYTES)) ? dm[mem_addr[AW-1:2]] : 32'd0;
    always @(posedge clk) begin
        if (mem_write && (mem_addr < 32'(MEM_BYTES))) dm[mem_addr[AW-1:2]] <= mem_wdata;
    end

    // Protocol watchers, checked once at the end.
    int n_overlap = 0;
    int n_idle_act = 0;
    always @(negedge clk) begin
        if (mem_read && mem_write) n_overlap++;
        if (!busy && (mem_read || mem_write)) n_idle_act++;
    end

    // Reference state.
    logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'd0};
    logic [31:0] exp_rd [2] = '{32'd0, 32'd0};
    bit          held [2] = '{1'b0, 1'b0};
    bit          prio_m = RST_PRIO;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [1:0] s, input logic [31:0] a);
        return (s == T_ILL) || (s == T_HALF && a[0]) || (s == T_WORD && a[1:0] != 2'b00)
            || ((a & 32'hFFFF_FFFC) > 32'(MEM_BYTES - 4));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v = '0;
        for (int i = 0; i < (1 << s); i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        for (int i = 0; i < (1 << s); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = r; we0 = w; size0 = s; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; size1 = s; addr1 = a; wdata1 = d; end
    endtask

    // One single-port transaction. With hold=1 req stays high after ack and the
    // next call on the same port re-drives operands during the ack cycle.
    task automatic txn(input int p, input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
        int cyc = 0, nrd = 0, nwr = 0, lat;
        bit e, done = 1'b0;
        logic [31:0] wr_word = '0, wr_addr = '0, exp_word;
        if (!held[p]) @(negedge clk);
        drive(p, 1'b1, w, s, a, d);
        e   = ref_err(s, a);
        lat = e ? 1 : ((!w || s == T_WORD) ? 2 : 3);
        if (held[p]) lat++;
        while (!done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wr_word = mem_wdata; wr_addr = mem_addr; end
            if ((p == 0) ? ack0 : ack1) done = 1'b1;
            else check("rdata_hold", (p == 0) ? rdata0 : rdata1, exp_rd[p]);
        end
        check("ack_seen", 32'(done), 32'd1);
        if (done) begin
            check("latency", 32'(cyc), 32'(lat));
            check("err", 32'((p == 0) ? err0 : err1), 32'(e));
            check("other_ack", 32'((p == 0) ? ack1 : ack0), 32'd0);
            check("mem_reads", 32'(nrd), (e || (w && s == T_WORD)) ? 32'd0 : 32'd1);
            check("mem_writes", 32'(nwr), (!e && w) ? 32'd1 : 32'd0);
            if (!e && w) begin
                ref_store(a, s, d);
                exp_word = ref_load(a & 32'hFFFF_FFFC, T_WORD);
                check("wr_word", wr_word, exp_word);
                check("wr_addr", wr_addr, a & 32'hFFFF_FFFC);
            end
            if (!e && !w) exp_rd[p] = ref_load(a, s);
            check("rdata", (p == 0) ? rdata0 : rdata1, exp_rd[p]);
            check("rdata_other", (p == 0) ? rdata1 : rdata0, exp_rd[1-p]);
        end
        if (!hold || !done) drive(p, 1'b0, 1'b0, T_BYTE, 32'd0, 32'd0);
        held[p] = hold && done;
    endtask

    task automatic rand_load(output logic [1:0] s, output logic [31:0] a);
        s = 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, MEM_BYTES - 1)) & ~((32'd1 << s) - 32'd1);
    endtask

    // Both ports keep loads pending; grants must follow the rotating pointer.
    task automatic contend(input int ngrants);
        logic [1:0]  cs [2];
        logic [31:0] ca [2];
        int got = 0, cyc = 0;
        int p;
        @(negedge clk);
        for (int q = 0; q < 2; q++) begin
            rand_load(cs[q], ca[q]);
            drive(q, 1'b1, 1'b0, cs[q], ca[q], 32'd0);
        end
        while (got < ngrants && cyc < BOUND * ngrants) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                check("cont_one_ack", 32'(ack0 && ack1), 32'd0);
                p = ack1 ? 1 : 0;
                check("cont_grant", 32'(p), 32'(prio_m));
                prio_m = ~prio_m;
                exp_rd[p] = ref_load(ca[p], cs[p]);
                check("cont_rdata", (p == 0) ? rdata0 : rdata1, exp_rd[p]);
                check("cont_err", 32'(err0 | err1), 32'd0);
                got++;
                if (got < ngrants) begin
                    rand_load(cs[p], ca[p]);
                    drive(p, 1'b1, 1'b0, cs[p], ca[p], 32'd0);
                end
            end
        end
        check("cont_done", 32'(got), 32'(ngrants));
        drive(0, 1'b0, 1'b0, T_BYTE, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, T_BYTE, 32'd0, 32'd0);
    endtask

    // Reset asserted while a sub-word store is in its write cycle.
    task automatic reset_in_write();
        int cyc = 0;
        bit seen = 1'b0, acked = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, T_BYTE, 32'h0000_0050, 32'h0000_0077);
        while (!seen && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (mem_write) seen = 1'b1;
        end
        check("rst_wr_reached", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mem_write_async", 32'(mem_write), 32'd0);
        check("rst_busy_async", 32'(busy), 32'd0);
        drive(0, 1'b0, 1'b0, T_BYTE, 32'd0, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (ack0 || ack1) acked = 1'b1;
        end
        rst_n = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        held[0]   = 1'b0;
        held[1]   = 1'b0;
        prio_m    = RST_PRIO;
        repeat (2) begin
            @(negedge clk);
            if (ack0 || ack1) acked = 1'b1;
        end
        check("rst_no_ack", 32'(acked), 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        int          p;
        bit          h;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_acks", 32'({ack1, ack0, err1, err0}), 32'd0);
        check("reset_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);

        contend(4);

        txn(0, 1'b1, T_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b0, T_WORD, 32'h10, 32'h0, 1'b0);
        txn(0, 1'b1, T_WORD, 32'h20, 32'h1122_3344, 1'b0);
        txn(0, 1'b1, T_BYTE, 32'h21, 32'hFFFF_FFAA, 1'b0);
        txn(0, 1'b0, T_BYTE, 32'h21, 32'h0, 1'b0);
        txn(1, 1'b1, T_HALF, 32'h22, 32'h0000_BEEF, 1'b0);
        txn(1, 1'b0, T_WORD, 32'h20, 32'h0, 1'b0);
        txn(0, 1'b0, T_HALF, 32'h31, 32'h0, 1'b0);
        txn(0, 1'b1, T_WORD, 32'h400, 32'h1234_5678, 1'b0);
        txn(1, 1'b0, T_ILL, 32'h40, 32'h0, 1'b0);
        txn(1, 1'b1, T_WORD, 32'h3FC, 32'hCAFE_F00D, 1'b0);
        txn(1, 1'b0, T_BYTE, 32'h3FF, 32'h0, 1'b0);
        txn(0, 1'b0, T_WORD, 32'h10, 32'h0, 1'b1);
        txn(0, 1'b0, T_WORD, 32'h20, 32'h0, 1'b0);

        reset_in_write();
        txn(0, 1'b0, T_WORD, 32'h50, 32'h0, 1'b0);
        contend(4);

        for (int i = 0; i < NRAND; i++) begin
            p = $urandom_range(0, 1);
            if (held[0]) p = 0;
            if (held[1]) p = 1;
            s = ($urandom_range(0, 15) == 0) ? T_ILL : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 32'(MEM_BYTES - 8) + 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0 && s != T_ILL) a = a & ~((32'd1 << s) - 32'd1);
            h = (i != NRAND - 1) && ($urandom_range(0, 3) == 0);
            txn(p, 1'($urandom_range(0, 1)), s, a, $urandom, h);
        end

        check("no_read_write_overlap", 32'(n_overlap), 32'd0);
        check("no_dm_access_when_idle", 32'(n_idle_act), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
